// File: rtl/leaf_stream_receiver.sv
// rtl/leaf_stream_receiver.sv - BFT leaf receive path: per-port FIFOs, user vld/ack streams, credit return; optional LEAF_RX_SEQ_CHECK_EN
module leaf_stream_receiver #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_IN_PORTS          = 1,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [PACKET_BITS-1:0]             din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]             dout_leaf_interface2bft,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0] dout_leaf_interface2user,
    output logic [NUM_IN_PORTS-1:0]            vld_interface2user,
    input  logic [NUM_IN_PORTS-1:0]            ack_user2interface,
    output logic [1:0]                         err
);
    localparam int DEPTH    = 1 << NUM_BRAM_ADDR_BITS;
    localparam int PTR_BITS = NUM_BRAM_ADDR_BITS + 1;
    localparam int POP_BITS = $clog2(FREESPACE_UPDATE_SIZE + 1);
    localparam int PORT_LSB = NUM_ADDR_BITS + PAYLOAD_BITS;
    localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;

    logic                     pkt_vld;
    logic [NUM_PORT_BITS-1:0] pkt_port;
    logic [PAYLOAD_BITS-1:0]  pkt_payload;
`ifdef LEAF_RX_SEQ_CHECK_EN
    logic [NUM_ADDR_BITS-1:0] pkt_addr;
    logic [NUM_IN_PORTS-1:0]  seq_bad;
`endif

    // The incoming leaf field and (in the default build) the addr field carry no meaning here.
    logic unused_din_bits;
    assign unused_din_bits = ^din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS]
                           ^ ^din_leaf_bft2interface[PAYLOAD_BITS +: NUM_ADDR_BITS];

    logic [PAYLOAD_BITS-1:0]  mem [NUM_IN_PORTS][DEPTH];
    logic [PTR_BITS-1:0]      wr_ptr [NUM_IN_PORTS];
    logic [PTR_BITS-1:0]      rd_ptr [NUM_IN_PORTS];
    logic [PTR_BITS-1:0]      mem_cnt [NUM_IN_PORTS];
    logic [PAYLOAD_BITS-1:0]  out_data [NUM_IN_PORTS];
    logic [NUM_IN_PORTS-1:0]  out_vld;
    logic [POP_BITS-1:0]      pop_cnt [NUM_IN_PORTS];
    logic [3:0]               pending [NUM_IN_PORTS];
    logic [NUM_IN_PORTS-1:0]  cfg_valid;
    logic [NUM_LEAF_BITS-1:0] cfg_leaf [NUM_IN_PORTS];
    logic [NUM_PORT_BITS-1:0] cfg_port [NUM_IN_PORTS];

    logic [NUM_IN_PORTS-1:0]  hit, full, seq_ok, push, drop_full, pop, load, wrap, inc, dec;
    logic [3:0]               cfg_sel;
    logic                     cfg_hit;
    logic                     arb_any;
    logic [NUM_LEAF_BITS-1:0] arb_leaf;
    logic [NUM_PORT_BITS-1:0] arb_port;

    logic                     gnt_vld;
    logic [NUM_LEAF_BITS-1:0] gnt_leaf;
    logic [NUM_PORT_BITS-1:0] gnt_port;

    // Register the incoming packet; every decision is made from this copy one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_vld     <= 1'b0;
            pkt_port    <= '0;
            pkt_payload <= '0;
        end else begin
            pkt_vld     <= din_leaf_bft2interface[PACKET_BITS-1];
            pkt_port    <= din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
            pkt_payload <= din_leaf_bft2interface[PAYLOAD_BITS-1:0];
        end
    end

`ifdef LEAF_RX_SEQ_CHECK_EN
    // Sequence field kept alongside the packet for the in-order check.
    always_ff @(posedge clk) begin
        if (reset) pkt_addr <= '0;
        else       pkt_addr <= din_leaf_bft2interface[PAYLOAD_BITS +: NUM_ADDR_BITS];
    end
`endif

    // Per-port push/pop decode; full uses registered occupancy so a same-cycle pop cannot make room.
    always_comb begin
        cfg_sel = pkt_payload[PAYLOAD_BITS-1 -: 4];
        cfg_hit = pkt_vld && (pkt_port == '0);
        for (int p = 0; p < NUM_IN_PORTS; p++) begin
            mem_cnt[p]   = wr_ptr[p] - rd_ptr[p];
            hit[p]       = pkt_vld && (pkt_port == NUM_PORT_BITS'(p + 1));
            full[p]      = (mem_cnt[p] + PTR_BITS'(out_vld[p])) == PTR_BITS'(DEPTH);
`ifdef LEAF_RX_SEQ_CHECK_EN
            seq_ok[p]    = (pkt_addr == NUM_ADDR_BITS'(wr_ptr[p]));
            seq_bad[p]   = hit[p] && !full[p] && !seq_ok[p];
`else
            seq_ok[p]    = 1'b1;
`endif
            push[p]      = hit[p] && !full[p] && seq_ok[p];
            drop_full[p] = hit[p] && full[p];
            pop[p]       = out_vld[p] && ack_user2interface[p];
            load[p]      = (mem_cnt[p] != '0) && (!out_vld[p] || ack_user2interface[p]);
            wrap[p]      = pop[p] && (pop_cnt[p] == POP_BITS'(FREESPACE_UPDATE_SIZE - 1));
        end
    end

    // Fixed-priority arbiter: lowest-index configured port with a pending credit.
    always_comb begin
        arb_any  = 1'b0;
        arb_leaf = '0;
        arb_port = '0;
        dec      = '0;
        for (int p = 0; p < NUM_IN_PORTS; p++) begin
            if (!arb_any && cfg_valid[p] && (pending[p] != 4'd0)) begin
                arb_any  = 1'b1;
                arb_leaf = cfg_leaf[p];
                arb_port = cfg_port[p];
                dec[p]   = 1'b1;
            end
        end
        for (int p = 0; p < NUM_IN_PORTS; p++) begin
            inc[p] = wrap[p] && ((pending[p] != 4'hF) || dec[p]);
        end
    end

    // Payload storage; no reset needed because the pointers define what is valid.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_IN_PORTS; p++) begin
            if (push[p]) mem[p][wr_ptr[p][NUM_BRAM_ADDR_BITS-1:0]] <= pkt_payload;
        end
    end

    // FIFO pointers, fall-through output register, credit counters and return-address config.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_IN_PORTS; p++) begin
            if (reset) begin
                wr_ptr[p]    <= '0;
                rd_ptr[p]    <= '0;
                out_vld[p]   <= 1'b0;
                out_data[p]  <= '0;
                pop_cnt[p]   <= '0;
                pending[p]   <= '0;
                cfg_valid[p] <= 1'b0;
                cfg_leaf[p]  <= '0;
                cfg_port[p]  <= '0;
            end else begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (load[p]) begin
                    out_data[p] <= mem[p][rd_ptr[p][NUM_BRAM_ADDR_BITS-1:0]];
                    out_vld[p]  <= 1'b1;
                    rd_ptr[p]   <= rd_ptr[p] + 1'b1;
                end else if (pop[p]) begin
                    out_vld[p]  <= 1'b0;
                end
                if (wrap[p])     pop_cnt[p] <= '0;
                else if (pop[p]) pop_cnt[p] <= pop_cnt[p] + 1'b1;
                pending[p] <= pending[p] + {3'b000, inc[p]} - {3'b000, dec[p]};
                if (cfg_hit && (cfg_sel == 4'(p + 1))) begin
                    cfg_valid[p] <= 1'b1;
                    cfg_leaf[p]  <= pkt_payload[NUM_PORT_BITS +: NUM_LEAF_BITS];
                    cfg_port[p]  <= pkt_payload[NUM_PORT_BITS-1:0];
                end
            end
        end
    end

    // Grant stage then packet stage: a credit leaves two cycles after the block completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_vld                 <= 1'b0;
            gnt_leaf                <= '0;
            gnt_port                <= '0;
            dout_leaf_interface2bft <= '0;
            err                     <= 2'b00;
        end else begin
            gnt_vld  <= arb_any;
            gnt_leaf <= arb_leaf;
            gnt_port <= arb_port;
            dout_leaf_interface2bft <= gnt_vld
                ? {1'b1, gnt_leaf, gnt_port, {NUM_ADDR_BITS{1'b1}}, PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)}
                : '0;
            err[0] <= err[0] | (|drop_full);
`ifdef LEAF_RX_SEQ_CHECK_EN
            err[1] <= err[1] | (|seq_bad);
`else
            err[1] <= 1'b0;
`endif
        end
    end

    // Flatten the per-port output registers; port 1 sits in the LSBs.
    always_comb begin
        dout_leaf_interface2user = '0;
        vld_interface2user       = out_vld;
        for (int p = 0; p < NUM_IN_PORTS; p++) begin
            dout_leaf_interface2user[p*PAYLOAD_BITS +: PAYLOAD_BITS] = out_data[p];
        end
    end
endmodule
